// File: rtl/reg_file_sequencer.sv
// Register-file sequencer: dumps every register over a valid/ready stream
// (two registers per read cycle) or clears registers 1..NUM_REGS-1 through
// the write port. NUM_REGS must be even and equal to 2**ADDR_W.
//
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both 1. Once out_valid rises it stays high, with out_addr
// and out_data held stable, until that transfer happens.
module reg_file_sequencer #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_dump,
  input  logic              start_clear,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_reg_i,
  output logic [DATA_W-1:0] rf_i_data,
  output logic              rf_w_enable,
  output logic [ADDR_W-1:0] rf_reg_j,
  output logic [ADDR_W-1:0] rf_reg_k,
  input  logic [DATA_W-1:0] rf_o_data_j,
  input  logic [DATA_W-1:0] rf_o_data_k,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        dbg_state
);

  localparam int P_W = ADDR_W - 1;
  localparam logic [P_W-1:0]    P_LAST  = P_W'(NUM_REGS / 2 - 1);
  localparam logic [P_W-1:0]    P_ONE   = P_W'(1);
  localparam logic [ADDR_W-1:0] W_FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_LAST  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    SEND_J = 3'd2,
    SEND_K = 3'd3,
    CLR    = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t            state;
  logic [P_W-1:0]    p;
  logic [P_W-1:0]    p_inc;
  logic [ADDR_W-1:0] w;
  logic [DATA_W-1:0] buf_j;
  logic [DATA_W-1:0] buf_k;

  assign p_inc     = p + P_ONE;
  assign dbg_state = state;

  // Clear only ever writes zero, so the write data is tied low.
  assign rf_i_data = '0;

  // Stream data comes straight from the capture buffers; zero when idle.
  always_comb begin
    out_data = '0;
    if (state == SEND_J)      out_data = buf_j;
    else if (state == SEND_K) out_data = buf_k;
  end

  // Command FSM; every control output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      p           <= '0;
      w           <= '0;
      buf_j       <= '0;
      buf_k       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rf_reg_i    <= '0;
      rf_w_enable <= 1'b0;
      rf_reg_j    <= '0;
      rf_reg_k    <= '0;
      out_valid   <= 1'b0;
      out_addr    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_dump) begin
            state    <= RD;
            p        <= '0;
            busy     <= 1'b1;
            rf_reg_j <= '0;
            rf_reg_k <= W_FIRST;
          end else if (start_clear) begin
            state       <= CLR;
            w           <= W_FIRST;
            busy        <= 1'b1;
            rf_w_enable <= 1'b1;
            rf_reg_i    <= W_FIRST;
          end
        end

        RD: begin
          buf_j     <= rf_o_data_j;
          buf_k     <= rf_o_data_k;
          rf_reg_j  <= '0;
          rf_reg_k  <= '0;
          out_valid <= 1'b1;
          out_addr  <= {p, 1'b0};
          state     <= SEND_J;
        end

        SEND_J: begin
          if (out_ready) begin
            out_addr <= {p, 1'b1};
            state    <= SEND_K;
          end
        end

        SEND_K: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            if (p == P_LAST) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              p        <= p_inc;
              rf_reg_j <= {p_inc, 1'b0};
              rf_reg_k <= {p_inc, 1'b1};
              state    <= RD;
            end
          end
        end

        CLR: begin
          if (w == W_LAST) begin
            rf_w_enable <= 1'b0;
            rf_reg_i    <= '0;
            done        <= 1'b1;
            state       <= FIN;
          end else begin
            w        <= w + W_FIRST;
            rf_reg_i <= w + W_FIRST;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy        <= 1'b0;
          rf_w_enable <= 1'b0;
          out_valid   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/reg_file_sequencer.md
Name: reg_file_sequencer

Overview:
- Initiator-side controller for the three-port register file: write port reg_i/i_data/w_enable, read ports reg_j/o_data_j and reg_k/o_data_k.
- Two commands:
  - Dump: reads all registers in pairs through the two read ports and streams them out over a valid/ready interface.
  - Clear: writes zero to registers 1..31 through the write port.
- Used for debug readout and post-boot register initialisation. It sits beside the datapath and drives the register file through a mux owned by the top level.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width
- NUM_REGS, 32, number of registers; must be even and equal to 2**ADDR_W

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start_dump  in  1  request a full-register dump; sampled only in IDLE
- start_clear  in  1  request a clear of regs 1..31; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a command completes
- rf_reg_i  out  ADDR_W  write address to the register file
- rf_i_data  out  DATA_W  write data to the register file
- rf_w_enable  out  1  write enable to the register file
- rf_reg_j  out  ADDR_W  read address, port j
- rf_reg_k  out  ADDR_W  read address, port k
- rf_o_data_j  in  DATA_W  read data, port j; combinational from rf_reg_j
- rf_o_data_k  in  DATA_W  read data, port k; combinational from rf_reg_k
- out_valid  out  1  stream word valid
- out_ready  in  1  stream consumer ready
- out_addr  out  ADDR_W  register index of the current stream word
- out_data  out  DATA_W  register value of the current stream word

Behaviour:
- Reset (rst_n low at a rising edge):
  - State goes to IDLE and the pair counter to 0.
  - All outputs go to 0, including busy, done, rf_w_enable and out_valid. The capture buffers are cleared.
  - Reset has priority over everything and aborts any command in progress. No partial handshake is completed, and no write occurs in the cycle after reset.
- States: IDLE, RD, SEND_J, SEND_K, CLR, FIN.
- IDLE:
  - start_dump=1: go to RD with pair counter p=0.
  - start_clear=1 and start_dump=0: go to CLR with write counter w=1.
  - If both starts are high, dump wins.
  - Starts in any non-IDLE state are ignored; they are not queued.
- RD:
  - Drive rf_reg_j=2p and rf_reg_k=2p+1.
  - At the end of the cycle, capture rf_o_data_j into buf_j and rf_o_data_k into buf_k. Then go to SEND_J.
- SEND_J:
  - out_valid=1, out_addr=2p, out_data=buf_j.
  - Stay until out_ready=1 at an edge, then go to SEND_K.
- SEND_K:
  - out_valid=1, out_addr=2p+1, out_data=buf_k.
  - On out_ready=1: if p=NUM_REGS/2-1, go to FIN; otherwise p=p+1 and go to RD.
- Stream handshake rules:
  - A transfer occurs on an edge where out_valid and out_ready are both 1.
  - While out_valid=1 and out_ready=0, out_addr and out_data are held stable. Once asserted, out_valid does not drop until the transfer.
  - out_valid=0 in RD, so there is one bubble per pair.
- CLR:
  - rf_w_enable=1, rf_reg_i=w, rf_i_data=0, one write per cycle.
  - When w=NUM_REGS-1, go to FIN; otherwise w=w+1.
  - Register 0 is never written. This takes 31 cycles.
- FIN: done=1 for exactly one cycle, busy=1, then go to IDLE.
- rf_w_enable is 0 in every state except CLR. In all other states rf_reg_i and rf_i_data are driven to 0.
- rf_reg_j and rf_reg_k are driven to 0 outside RD. Holding the last read address is also permitted, because the read ports have no side effects.
- Latency:
  - start_dump sampled at edge t gives busy=1 after t and the first out_valid after t+1.
  - With out_ready held at 1: 3 cycles per pair, 48 cycles total. done is high in the cycle after the last transfer.
  - Clear: start at t, 31 write cycles, then done in the following cycle. busy lasts 32 cycles.
- Counters: p is ADDR_W-1 bits wide and w is ADDR_W bits wide. Both saturate at their terminal values via the state transition; they never wrap.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with start_dump=1. Required: busy, done, out_valid and rf_w_enable all 0; state stays IDLE until rst_n=1.
- Full dump: bench reg-file model preloaded r[n]=n*32'h01010101, start_dump pulsed, out_ready=1. Required: 32 transfers with out_addr 0..31 in order and out_data=r[out_addr]; done pulses 48 cycles after start; rf_w_enable is never 1.
- Backpressure: during a dump, drop out_ready for 5 cycles at word 7. Required: out_addr=7 and out_data=r[7] held stable with out_valid=1; no word is skipped or duplicated; total transfers = 32.
- Clear then dump: r0=32'hDEADBEEF with all other registers nonzero; run clear, then dump. Required: rf_reg_i steps 1..31 with rf_i_data=0 over 31 consecutive cycles; the dump then shows r0=32'hDEADBEEF and r1..r31=0.
- Start priority and ignore: raise start_dump and start_clear together. Required: a dump runs. Pulse start_clear mid-dump. Required: ignored, no write occurs, and only one done pulse is produced.
- Reset mid-dump: assert rst_n=0 after word 10 transfers. Required: the next cycle shows out_valid=0 and busy=0. A new start_dump restarts at out_addr=0.
